// File: rtl/riscv_trace_tx.sv
// Commit-trace transmitter: samples REG/MEMW/MEMR events from the core,
// queues them as 43-bit tagged entries and streams each one out as a
// 6-byte frame over a byte-wide valid/ready interface.
module riscv_trace_tx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 9
) (
    input  logic                     tb_clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     reg_write_sig,
    input  logic [4:0]               reg_num,
    input  logic [31:0]              reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              wr_data,
    input  logic [31:0]              rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    // entry layout: [42:41] type, [40:32] idx, [31:0] data
    logic [42:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [2:0]    ev;
    logic [42:0]   ent [3];
    logic [8:0]    addr_idx;
    logic [1:0]    n_ev;
    logic [LW-1:0] free;
    logic          push_ok;
    logic [AW-1:0] off1, off2;
    logic [16:0]   drop_sum;

    state_t        state, state_nx;
    logic [2:0]    cnt;
    logic [42:0]   frame;
    logic          empty, accept, last, pop;

    assign addr_idx   = 9'(addr);
    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (fifo_level == '0);

    // Event decode, entry build and all-or-nothing admission check.
    // Free space is taken from the registered level, so a pop on the
    // same edge never makes room for this cycle's events.
    always_comb begin
        ev[0]    = trace_en & reg_write_sig & (reg_num != 5'd0);
        ev[1]    = trace_en & wr;
        ev[2]    = trace_en & rd;
        ent[0]   = {2'b01, 4'b0000, reg_num, reg_data};
        ent[1]   = {2'b10, addr_idx, wr_data};
        ent[2]   = {2'b11, addr_idx, rd_data};
        n_ev     = {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};
        free     = LW'(DEPTH) - fifo_level;
        push_ok  = (n_ev != 2'd0) && (LW'(n_ev) <= free);
        off1     = AW'(ev[0]);
        off2     = AW'(ev[0]) + AW'(ev[1]);
        drop_sum = 17'(drop_count) + 17'(n_ev);
    end

    // FIFO storage: compacted write of up to three entries in REG, MEMW, MEMR order.
    always_ff @(posedge tb_clk) begin
        if (push_ok) begin
            if (ev[0]) mem[wr_ptr[AW-1:0]]        <= ent[0];
            if (ev[1]) mem[wr_ptr[AW-1:0] + off1] <= ent[1];
            if (ev[2]) mem[wr_ptr[AW-1:0] + off2] <= ent[2];
        end
    end

    // FIFO pointers and saturating drop counter.
    always_ff @(posedge tb_clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + LW'(n_ev);
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (n_ev != 2'd0 && !push_ok)
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign accept = tx_valid & tx_ready;
    assign last   = accept && (cnt == 3'd5);
    assign pop    = !empty && ((state == IDLE) || last);

    // Serializer state register.
    always_ff @(posedge tb_clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Serializer next state: the final byte chains straight into the next frame.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty)        state_nx = SEND;
            SEND:    if (last && empty) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // Serializer outputs: byte select from the held frame keeps tx_data stable under stall.
    always_comb begin
        tx_valid = (state == SEND);
        tx_data  = 8'h00;
        if (state == SEND) begin
            case (cnt)
                3'd0:    tx_data = {frame[42:41], 5'b00000, frame[40]};
                3'd1:    tx_data = frame[39:32];
                3'd2:    tx_data = frame[31:24];
                3'd3:    tx_data = frame[23:16];
                3'd4:    tx_data = frame[15:8];
                default: tx_data = frame[7:0];
            endcase
        end
    end

    // Frame register and byte counter.
    always_ff @(posedge tb_clk) begin
        if (!reset) begin
            frame <= '0;
            cnt   <= '0;
        end else if (pop) begin
            frame <= mem[rd_ptr[AW-1:0]];
            cnt   <= '0;
        end else if (accept) begin
            cnt   <= cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_riscv_trace_tx.sv
// Scoreboard bench for riscv_trace_tx: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_riscv_trace_tx;
    logic        tb_clk = 0;
    logic        reset = 0;
    logic        trace_en = 1;
    logic        reg_write_sig = 0;
    logic [4:0]  reg_num = 0;
    logic [31:0] reg_data = 0;
    logic        wr = 0, rd = 0;
    logic [8:0]  addr = 0;
    logic [31:0] wr_data = 0, rd_data = 0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 0;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    riscv_trace_tx #(.DEPTH(16), .ADDR_W(9)) dut (
        .tb_clk(tb_clk), .reset(reset), .trace_en(trace_en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 tb_clk = ~tb_clk;

    int       cyc = 0;
    int       n_cmp = 0, n_err = 0;
    bit       rnd_on = 0;
    logic [7:0] exp_q[$];
    int       acc_q[$];
    bit       prev_stall = 0;
    logic [7:0] prev_data = 0;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: accepted bytes vs scoreboard, plus stall stability.
    always @(negedge tb_clk) begin
        if (!reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                acc_q.push_back(cyc + 1);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic tick();
        @(posedge tb_clk); #1;
        if (rnd_on) tx_ready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic push_frame(input logic [1:0] t, input logic [8:0] idx, input logic [31:0] d);
        exp_q.push_back({t, 5'b00000, idx[8]});
        exp_q.push_back(idx[7:0]);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    // Drive one cycle of events; they are sampled at the next edge.
    task automatic issue(input bit rv, input logic [4:0] rn, input logic [31:0] rdv,
                         input bit wv, input bit dv, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] rdd, input bit exp_push);
        reg_write_sig = rv; reg_num = rn; reg_data = rdv;
        wr = wv; rd = dv; addr = a; wr_data = wd; rd_data = rdd;
        if (exp_push) begin
            if (rv && rn != 5'd0) push_frame(2'b01, {4'b0000, rn}, rdv);
            if (wv) push_frame(2'b10, a, wd);
            if (dv) push_frame(2'b11, a, rdd);
        end
        tick();
        reg_write_sig = 0; wr = 0; rd = 0;
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin tick(); b++; end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        reset = 0; tx_ready = 0; rnd_on = 0;
        tick(); tick();
        exp_q.delete(); acc_q.delete();
        reset = 1;
        tick();
    endtask

    int n0;

    initial begin
        // reset state
        reset = 0;
        tick(); tick();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        do_reset();

        // 1: single REG event
        tx_ready = 1;
        issue(1, 5'd5, 32'h1234_5678, 0, 0, 9'd0, 0, 0, 1);
        n0 = cyc;
        drain(50);
        check("t1_idle", 32'(tx_valid), 32'd0);
        check("t1_nbytes", 32'(acc_q.size()), 32'd6);
        if (acc_q.size() == 6) begin
            check("t1_first_edge", 32'(acc_q[0]), 32'(n0 + 2));
            check("t1_last_edge", 32'(acc_q[5]), 32'(n0 + 7));
        end

        // 2: three events in one cycle (shared address port)
        do_reset();
        tx_ready = 1;
        issue(1, 5'd1, 32'h0000_000A, 1, 1, 9'h104, 32'hDEAD_BEEF, 32'h0000_0007, 1);
        n0 = cyc;
        drain(100);
        check("t2_nbytes", 32'(acc_q.size()), 32'd18);
        if (acc_q.size() == 18) begin
            check("t2_first_edge", 32'(acc_q[0]), 32'(n0 + 2));
            check("t2_span", 32'(acc_q[17] - acc_q[0]), 32'd17);
        end

        // 3: filtering
        do_reset();
        tx_ready = 1;
        issue(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 9'd0, 0, 0, 0);
        check("t3_x0_level", 32'(fifo_level), 32'd0);
        trace_en = 0;
        issue(1, 5'd7, 32'h1111_1111, 1, 1, 9'h0AA, 32'h2222_2222, 32'h3333_3333, 0);
        check("t3_dis_level", 32'(fifo_level), 32'd0);
        trace_en = 1;
        repeat (4) tick();
        check("t3_valid", 32'(tx_valid), 32'd0);
        check("t3_level", 32'(fifo_level), 32'd0);

        // 4: backpressure, 20 events in 10 two-event cycles
        do_reset();
        rnd_on = 1;
        for (int i = 0; i < 10; i++) begin
            int b = 0;
            while (fifo_level > 5'd10 && b < 500) begin tick(); b++; end
            if (i % 2 == 0)
                issue(1, 5'(i + 1), 32'hA500_0000 + 32'(i), 1, 0, 9'(9'h100 + i), 32'h0BAD_0000 + 32'(i), 0, 1);
            else
                issue(1, 5'(i + 1), 32'h5A00_0000 + 32'(i), 0, 1, 9'(i), 0, 32'hC0DE_0000 + 32'(i), 1);
        end
        drain(3000);
        rnd_on = 0;
        check("t4_drop", 32'(drop_count), 32'd0);

        // 5: overflow
        do_reset();
        tx_ready = 0;
        issue(0, 5'd0, 0, 1, 0, 9'h1F0, 32'hF000_0000, 0, 1);
        tick(); tick();
        for (int i = 0; i < 16; i++)
            issue(0, 5'd0, 0, 1, 0, 9'(i), 32'hE000_0000 + 32'(i), 0, 1);
        check("t5_full", 32'(fifo_level), 32'd16);
        issue(0, 5'd0, 0, 1, 0, 9'h1FF, 32'h9999_9999, 0, 0);
        check("t5_drop1", 32'(drop_count), 32'd1);
        check("t5_full_keep", 32'(fifo_level), 32'd16);
        tx_ready = 1;
        repeat (12) tick();
        tx_ready = 0;
        check("t5_lvl14", 32'(fifo_level), 32'd14);
        issue(1, 5'd7, 32'h7777_7777, 1, 1, 9'h077, 32'h8888_8888, 32'h6666_6666, 0);
        check("t5_drop4", 32'(drop_count), 32'd4);
        check("t5_lvl14_keep", 32'(fifo_level), 32'd14);
        tx_ready = 1;
        drain(300);
        check("t5_drop_final", 32'(drop_count), 32'd4);

        // 6: reset mid-frame after B2 accepted
        do_reset();
        tx_ready = 1;
        issue(1, 5'd9, 32'hCAFE_F00D, 1, 0, 9'h055, 32'h0000_0001, 0, 1);
        repeat (4) tick();
        check("t6_b2_seen", 32'(acc_q.size()), 32'd3);
        reset = 0; tx_ready = 0;
        tick();
        check("t6_valid", 32'(tx_valid), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_drop", 32'(drop_count), 32'd0);
        exp_q.delete(); acc_q.delete();
        reset = 1; tx_ready = 1;
        tick();
        issue(1, 5'd3, 32'h0BAD_BEEF, 0, 0, 9'd0, 0, 0, 1);
        n0 = cyc;
        drain(50);
        check("t6_nbytes", 32'(acc_q.size()), 32'd6);
        if (acc_q.size() == 6) check("t6_first_edge", 32'(acc_q[0]), 32'(n0 + 2));
        check("t6_idle", 32'(tx_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
